branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//   Sequences conditional-branch resolution between decode and fetch. Accepts one branch at a time
//   over a valid/ready handshake. Drives the shared registered comparator `cond` (1-cycle latency)
//   and computes the branch target. Reports the outcome, issues a held fetch redirect when taken,
//   and keeps saturating branch and taken counters.
// PARAMETERS
//   XLEN  32  datapath width (pc, operands, immediate)
//   CNT_W 32  width of the statistics counters (saturating)
// PORTS
//   clk            in   1      clock, all state updates on posedge
//   reset          in   1      synchronous, active-high reset
//   req_valid      in   1      decode offers a branch
//   req_ready      out  1      controller can accept (high only in IDLE)
//   req_funct3     in   3      branch funct3 (000 BEQ,001 BNE,100 BLT,101 BGE,110 BLTU,111 BGEU)
//   req_rs1        in   XLEN   first operand
//   req_rs2        in   XLEN   second operand
//   req_pc         in   XLEN   pc of the branch
//   req_imm        in   XLEN   sign-extended branch offset
//   cmp_funct3     out  3      to `cond` funct3
//   cmp_x          out  XLEN   to `cond` x
//   cmp_y          out  XLEN   to `cond` y
//   cmp_out        in   1      from `cond` out (registered, valid the cycle after inputs are driven)
//   resp_valid     out  1      one-cycle outcome pulse
//   resp_taken     out  1      branch taken (valid with resp_valid)
//   resp_illegal   out  1      funct3 010/011 (valid with resp_valid)
//   resp_misalign  out  1      taken with target[1:0]!=0 (valid with resp_valid)
//   redir_valid    out  1      fetch redirect request
//   redir_ready    in   1      fetch accepts redirect
//   redir_pc       out  XLEN   redirect target
//   stat_branches  out  CNT_W  resolved legal branches, saturating
//   stat_taken     out  CNT_W  redirects accepted, saturating
// BEHAVIOUR
//   - Reset:
//     - state=IDLE; every output and latched register is 0, except req_ready=1.
//     - A mid-operation reset abandons the branch; redir_valid is 0 the cycle after the reset edge.
//   - States:
//     - IDLE:
//       - req_ready=1.
//       - On req_valid&req_ready, latch funct3/rs1/rs2/pc/imm.
//       - funct3 in {010,011}: go to ILL. Otherwise go to CMP.
//     - ILL: resp_valid=1, resp_illegal=1, resp_taken=0; no counters change; go to IDLE.
//     - CMP: cmp_* = latched funct3/rs1/rs2 (held stable from the latch edge through EVAL); go to EVAL.
//     - EVAL:
//       - resp_valid=1; resp_taken=cmp_out; target=pc+imm mod 2^XLEN (carry dropped).
//       - resp_misalign = cmp_out & (target[1:0]!=0).
//       - stat_branches += 1 (sticks at all-ones).
//       - If taken and aligned: redir_pc<=target, go to REDIR. Otherwise go to IDLE.
//     - REDIR:
//       - redir_valid=1; redir_pc held stable.
//       - On redir_ready: stat_taken += 1 (saturating), go to IDLE.
//       - Waits indefinitely while redir_ready=0.
//   - Timing:
//     - Latency: accept edge = cycle 0; CMP cycle 1; resp_valid cycle 2; redir_valid from cycle 3.
//     - Illegal: resp_valid in cycle 1.
//     - Throughput: at most one branch in flight; req_ready=0 in every non-IDLE state.
//     - Back-to-back: returning to IDLE allows a new accept on the following edge.
//   - Outputs outside their state:
//     - resp_* are 0 outside ILL/EVAL.
//     - redir_valid is 0 outside REDIR; redir_pc retains its last value.
//     - cmp_* retain their last values outside CMP/EVAL.
//   - Signedness: the controller does no comparison itself; BLT/BGE signedness comes from `cond`.
// TESTING
//   1. BEQ rs1=rs2=5, pc=0x100, imm=0x20, redir_ready=1
//      -> resp_valid@c2 taken=1; redir_valid@c3 redir_pc=0x120; stat_taken=1.
//   2. BLT rs1=0xFFFFFFFF, rs2=1 -> taken, redirect.
//      Same operands with BLTU -> resp_taken=0, no redir_valid, stat_branches=2.
//   3. funct3=010 -> resp_valid&resp_illegal@c1; no redirect; counters unchanged; req_ready=1@c2.
//   4. Taken branch, redir_ready low 4 cycles then high
//      -> redir_valid/redir_pc stable for 5 cycles; req_ready=0 throughout; IDLE after handshake.
//   5. pc=0xFFFFFFF0, imm=0x20, BNE 1,2 -> redir_pc=0x10 (wrap).
//      imm=0x2 taken -> resp_misalign=1, no redir_valid.
//   6. reset asserted in REDIR -> next cycle redir_valid=0, req_ready=1, stats=0.
//      CNT_W=2 with 5 legal branches -> stat_branches=3.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl_if
// Purpose  : Decode request, comparator, response, redirect and statistics
//            signals of the branch resolution controller.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_resolve_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  req_imm;
    logic [2:0]       cmp_funct3;
    logic [XLEN-1:0]  cmp_x;
    logic [XLEN-1:0]  cmp_y;
    logic             cmp_out;
    logic             resp_valid;
    logic             resp_taken;
    logic             resp_illegal;
    logic             resp_misalign;
    logic             redir_valid;
    logic             redir_ready;
    logic [XLEN-1:0]  redir_pc;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_taken;

    // Controller side.
    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
               cmp_out, redir_ready,
        output req_ready, cmp_funct3, cmp_x, cmp_y,
               resp_valid, resp_taken, resp_illegal, resp_misalign,
               redir_valid, redir_pc, stat_branches, stat_taken
    );

    // Decode / comparator / fetch side.
    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
               cmp_out, redir_ready,
        input  req_ready, cmp_funct3, cmp_x, cmp_y,
               resp_valid, resp_taken, resp_illegal, resp_misalign,
               redir_valid, redir_pc, stat_branches, stat_taken
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_ctrl
// Purpose  : Resolves one conditional branch at a time using an external
//            registered comparator, then reports and redirects fetch.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input wire                    clk,
    input wire                    reset,
    branch_resolve_ctrl_if.slave  br_if
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ILL   = 3'd1,
        S_CMP   = 3'd2,
        S_EVAL  = 3'd3,
        S_REDIR = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t            r_state;
    logic              r_req_ready;
    logic [2:0]        r_cmp_funct3;
    logic [XLEN-1:0]   r_cmp_x;
    logic [XLEN-1:0]   r_cmp_y;
    logic [XLEN-1:0]   r_target;
    logic              r_resp_valid;
    logic              r_resp_illegal;
    logic              r_redir_valid;
    logic [XLEN-1:0]   r_redir_pc;
    logic [CNT_W-1:0]  r_stat_branches;
    logic [CNT_W-1:0]  r_stat_taken;

    logic w_req_ill;
    logic w_taken;
    logic w_misalign;
    logic w_redir;

    // cmp_out is only meaningful in EVAL, so the outcome is gated by state.
    assign w_req_ill  = (br_if.req_funct3[2:1] == 2'b01);
    assign w_taken    = (r_state == S_EVAL) & br_if.cmp_out;
    assign w_misalign = w_taken & (r_target[1:0] != 2'b00);
    assign w_redir    = w_taken & ~w_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_req_ready     <= 1'b1;
            r_cmp_funct3    <= '0;
            r_cmp_x         <= '0;
            r_cmp_y         <= '0;
            r_target        <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_illegal  <= 1'b0;
            r_redir_valid   <= 1'b0;
            r_redir_pc      <= '0;
            r_stat_branches <= '0;
            r_stat_taken    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (br_if.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_target    <= br_if.req_pc + br_if.req_imm;
                        if (w_req_ill) begin
                            r_state        <= S_ILL;
                            r_resp_valid   <= 1'b1;
                            r_resp_illegal <= 1'b1;
                        end else begin
                            r_state      <= S_CMP;
                            r_cmp_funct3 <= br_if.req_funct3;
                            r_cmp_x      <= br_if.req_rs1;
                            r_cmp_y      <= br_if.req_rs2;
                        end
                    end
                end
                S_ILL: begin
                    r_resp_valid   <= 1'b0;
                    r_resp_illegal <= 1'b0;
                    r_req_ready    <= 1'b1;
                    r_state        <= S_IDLE;
                end
                S_CMP: begin
                    r_resp_valid <= 1'b1;
                    r_state      <= S_EVAL;
                end
                S_EVAL: begin
                    r_resp_valid <= 1'b0;
                    if (r_stat_branches != c_CNT_MAX) begin
                        r_stat_branches <= r_stat_branches + 1'b1;
                    end
                    if (w_redir) begin
                        r_redir_pc    <= r_target;
                        r_redir_valid <= 1'b1;
                        r_state       <= S_REDIR;
                    end else begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_REDIR: begin
                    if (br_if.redir_ready) begin
                        r_redir_valid <= 1'b0;
                        r_req_ready   <= 1'b1;
                        r_state       <= S_IDLE;
                        if (r_stat_taken != c_CNT_MAX) begin
                            r_stat_taken <= r_stat_taken + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_req_ready    <= 1'b1;
                    r_resp_valid   <= 1'b0;
                    r_resp_illegal <= 1'b0;
                    r_redir_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign br_if.req_ready     = r_req_ready;
    assign br_if.cmp_funct3    = r_cmp_funct3;
    assign br_if.cmp_x         = r_cmp_x;
    assign br_if.cmp_y         = r_cmp_y;
    assign br_if.resp_valid    = r_resp_valid;
    assign br_if.resp_taken    = w_taken;
    assign br_if.resp_illegal  = r_resp_illegal;
    assign br_if.resp_misalign = w_misalign;
    assign br_if.redir_valid   = r_redir_valid;
    assign br_if.redir_pc      = r_redir_pc;
    assign br_if.stat_branches = r_stat_branches;
    assign br_if.stat_taken    = r_stat_taken;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_ctrl
// Purpose  : Self-checking bench for branch_resolve_ctrl with a comparator stub
//            and a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.XLEN(32), .CNT_W(32)) bus ();
    branch_resolve_ctrl_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(32)) dut  (.clk(clk), .reset(reset), .br_if(bus.slave));
    branch_resolve_ctrl #(.XLEN(32), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .br_if(bus2.slave));

    assign bus2.req_valid   = bus.req_valid;
    assign bus2.req_funct3  = bus.req_funct3;
    assign bus2.req_rs1     = bus.req_rs1;
    assign bus2.req_rs2     = bus.req_rs2;
    assign bus2.req_pc      = bus.req_pc;
    assign bus2.req_imm     = bus.req_imm;
    assign bus2.redir_ready = bus.redir_ready;

    // Registered comparator stub standing in for `cond`.
    function automatic logic cond_stub(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        case (f)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return $signed(x) <  $signed(y);
            3'b101:  return $signed(x) >= $signed(y);
            3'b110:  return x <  y;
            3'b111:  return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) bus.cmp_out  <= cond_stub(bus.cmp_funct3, bus.cmp_x, bus.cmp_y);
    always @(posedge clk) bus2.cmp_out <= cond_stub(bus2.cmp_funct3, bus2.cmp_x, bus2.cmp_y);

    // ---------------- reference model ----------------
    logic [31:0] exp_br, exp_tk;
    logic [1:0]  exp2_br, exp2_tk;
    logic        m_ill, m_taken, m_mis, m_redir;
    logic [31:0] m_target;

    function automatic logic ref_outcome(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] sa, sb;
        sa = a ^ 32'h8000_0000;
        sb = b ^ 32'h8000_0000;
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return !(sa < sb);
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_apply(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] pc, input logic [31:0] imm);
        m_ill    = (f == 3'b010) || (f == 3'b011);
        m_taken  = !m_ill && ref_outcome(f, a, b);
        m_target = pc + imm;
        m_mis    = m_taken && (m_target % 4 != 0);
        m_redir  = m_taken && !m_mis;
        if (!m_ill) begin
            if (exp_br != 32'hFFFF_FFFF) exp_br = exp_br + 1;
            if (exp2_br != 2'd3) exp2_br = exp2_br + 1;
        end
        if (m_redir) begin
            if (exp_tk != 32'hFFFF_FFFF) exp_tk = exp_tk + 1;
            if (exp2_tk != 2'd3) exp2_tk = exp2_tk + 1;
        end
    endtask

    task automatic model_reset();
        exp_br = 0; exp_tk = 0; exp2_br = 0; exp2_tk = 0;
    endtask

    // ---------------- driver / observer ----------------
    int          o_wait, o_resp_cyc, o_redir_cyc;
    logic        o_taken, o_ill, o_mis, o_redir, o_cmp_ok, o_busy_ok, o_hold_ok, o_ready_after;
    logic [31:0] o_redir_pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] imm, input int stall);
        o_wait = 0;
        while (!bus.req_ready && o_wait < 20) begin
            tick();
            o_wait++;
        end
        bus.req_funct3 = f; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_pc = pc; bus.req_imm = imm;
        bus.req_valid  = 1'b1;
        tick();
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'($urandom); bus.req_rs1 = $urandom; bus.req_rs2 = $urandom;
        bus.req_pc     = $urandom;     bus.req_imm = $urandom;
        o_resp_cyc = 0; o_taken = 0; o_ill = 0; o_mis = 0; o_cmp_ok = 1; o_busy_ok = 1;
        for (int c = 1; c <= 6 && o_resp_cyc == 0; c++) begin
            if (bus.req_ready) o_busy_ok = 0;
            if ((f[2:1] != 2'b01) && (bus.cmp_funct3 !== f || bus.cmp_x !== a || bus.cmp_y !== b)) o_cmp_ok = 0;
            if (bus.resp_valid) begin
                o_resp_cyc = c;
                o_taken = bus.resp_taken; o_ill = bus.resp_illegal; o_mis = bus.resp_misalign;
            end else if (bus.resp_taken || bus.resp_illegal || bus.resp_misalign) begin
                o_busy_ok = 0;
            end
            tick();
        end
        o_redir = bus.redir_valid; o_redir_pc = bus.redir_pc; o_redir_cyc = 0; o_hold_ok = 1;
        if (o_redir) begin
            while (bus.redir_valid && o_redir_cyc < stall + 10) begin
                o_redir_cyc++;
                if (bus.redir_pc !== o_redir_pc || bus.req_ready || bus.resp_valid) o_hold_ok = 0;
                bus.redir_ready = (o_redir_cyc > stall);
                tick();
            end
            bus.redir_ready = 1'b0;
        end
        o_ready_after = bus.req_ready;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.req_valid = 0; bus.redir_ready = 0; bus.req_funct3 = 0;
        bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_pc = 0; bus.req_imm = 0;
        reset = 1'b1;
        repeat (3) tick();
        model_reset();
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        total++; if ({bus.resp_valid, bus.resp_taken, bus.resp_illegal, bus.resp_misalign, bus.redir_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {bus.resp_valid, bus.resp_taken, bus.resp_illegal, bus.resp_misalign, bus.redir_valid}); end
        total++; if ({bus.redir_pc, bus.cmp_x, bus.cmp_y, bus.cmp_funct3} !== '0) begin
            bad++; $display("FAIL reset_regs: got %h %h %h %h want 0", bus.redir_pc, bus.cmp_x, bus.cmp_y, bus.cmp_funct3); end
        total++; if ({bus.stat_branches, bus.stat_taken, bus2.stat_branches, bus2.stat_taken} !== '0) begin
            bad++; $display("FAIL reset_stats: got %0d %0d %0d %0d want 0", bus.stat_branches, bus.stat_taken, bus2.stat_branches, bus2.stat_taken); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_beq_taken();
        model_apply(3'b000, 32'd5, 32'd5, 32'h100, 32'h20);
        drive_branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 0);
        total++; if (o_resp_cyc !== 2 || o_taken !== 1'b1) begin bad++; $display("FAIL beq_resp: got cyc=%0d taken=%b want cyc=2 taken=1", o_resp_cyc, o_taken); end
        total++; if (o_redir !== 1'b1 || o_redir_pc !== 32'h120) begin bad++; $display("FAIL beq_redir: got v=%b pc=%h want v=1 pc=120", o_redir, o_redir_pc); end
        total++; if (!o_cmp_ok || !o_busy_ok) begin bad++; $display("FAIL beq_cmp_busy: got cmp=%b busy=%b want 1 1", o_cmp_ok, o_busy_ok); end
        total++; if (bus.stat_taken !== exp_tk || bus.stat_branches !== exp_br) begin
            bad++; $display("FAIL beq_stats: got %0d/%0d want %0d/%0d", bus.stat_branches, bus.stat_taken, exp_br, exp_tk); end
    endtask

    task automatic test_signed_unsigned();
        model_apply(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        drive_branch(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0);
        total++; if (o_taken !== m_taken || o_redir !== m_redir || o_redir_pc !== m_target) begin
            bad++; $display("FAIL blt_signed: got t=%b r=%b pc=%h want t=%b r=%b pc=%h", o_taken, o_redir, o_redir_pc, m_taken, m_redir, m_target); end
        model_apply(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40);
        drive_branch(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0);
        total++; if (o_taken !== 1'b0 || o_redir !== 1'b0) begin bad++; $display("FAIL bltu_unsigned: got t=%b r=%b want 0 0", o_taken, o_redir); end
        total++; if (bus.stat_branches !== exp_br) begin bad++; $display("FAIL bltu_stat: got %0d want %0d", bus.stat_branches, exp_br); end
    endtask

    task automatic test_illegal();
        logic [31:0] br_before, tk_before;
        br_before = bus.stat_branches; tk_before = bus.stat_taken;
        model_apply(3'b010, 32'd3, 32'd3, 32'h300, 32'h8);
        drive_branch(3'b010, 32'd3, 32'd3, 32'h300, 32'h8, 0);
        total++; if (o_resp_cyc !== 1 || o_ill !== 1'b1 || o_taken !== 1'b0) begin
            bad++; $display("FAIL illegal_resp: got cyc=%0d ill=%b t=%b want 1 1 0", o_resp_cyc, o_ill, o_taken); end
        total++; if (o_redir !== 1'b0 || o_ready_after !== 1'b1) begin bad++; $display("FAIL illegal_ready: got r=%b rdy=%b want 0 1", o_redir, o_ready_after); end
        total++; if (bus.stat_branches !== br_before || bus.stat_taken !== tk_before) begin
            bad++; $display("FAIL illegal_stats: got %0d/%0d want %0d/%0d", bus.stat_branches, bus.stat_taken, br_before, tk_before); end
    endtask

    task automatic test_redir_stall();
        model_apply(3'b001, 32'd1, 32'd2, 32'h400, 32'h10);
        drive_branch(3'b001, 32'd1, 32'd2, 32'h400, 32'h10, 4);
        total++; if (o_redir_cyc !== 5 || !o_hold_ok) begin bad++; $display("FAIL stall_hold: got cyc=%0d hold=%b want 5 1", o_redir_cyc, o_hold_ok); end
        total++; if (o_redir_pc !== 32'h410 || o_ready_after !== 1'b1) begin bad++; $display("FAIL stall_end: got pc=%h rdy=%b want 410 1", o_redir_pc, o_ready_after); end
        total++; if (bus.stat_taken !== exp_tk) begin bad++; $display("FAIL stall_taken: got %0d want %0d", bus.stat_taken, exp_tk); end
    endtask

    task automatic test_wrap_misalign();
        model_apply(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20);
        drive_branch(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1);
        total++; if (o_redir !== 1'b1 || o_redir_pc !== 32'h10) begin bad++; $display("FAIL wrap_pc: got r=%b pc=%h want 1 10", o_redir, o_redir_pc); end
        model_apply(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h2);
        drive_branch(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h2, 0);
        total++; if (o_mis !== 1'b1 || o_taken !== 1'b1 || o_redir !== 1'b0) begin
            bad++; $display("FAIL misalign: got mis=%b t=%b r=%b want 1 1 0", o_mis, o_taken, o_redir); end
        total++; if (bus.redir_pc !== 32'h10 || bus.stat_branches !== exp_br) begin
            bad++; $display("FAIL misalign_keep: got pc=%h br=%0d want 10 %0d", bus.redir_pc, bus.stat_branches, exp_br); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] fs [3];
        fs[0] = 3'b000; fs[1] = 3'b011; fs[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            model_apply(fs[i], 32'd9, 32'd8, 32'h500, 32'h4);
            drive_branch(fs[i], 32'd9, 32'd8, 32'h500, 32'h4, 0);
            total++; if (o_wait !== 0 || o_resp_cyc !== (m_ill ? 1 : 2)) begin
                bad++; $display("FAIL b2b_%0d: got wait=%0d cyc=%0d want 0 %0d", i, o_wait, o_resp_cyc, m_ill ? 1 : 2); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, pc, imm;
        int          stall;
        for (int i = 0; i < 40; i++) begin
            f     = 3'($urandom_range(0, 7));
            a     = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) - 32'd2 : $urandom;
            b     = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc    = $urandom & 32'hFFFF_FFFC;
            imm   = 32'($urandom_range(0, 511)) - 32'd256;
            imm   = ($urandom_range(0, 4) == 0) ? imm : (imm & 32'hFFFF_FFFC);
            stall = $urandom_range(0, 3);
            model_apply(f, a, b, pc, imm);
            drive_branch(f, a, b, pc, imm, stall);
            total++; if (o_wait !== 0 || o_resp_cyc !== (m_ill ? 1 : 2)) begin
                bad++; $display("FAIL rnd_timing[%0d]: got wait=%0d cyc=%0d want 0 %0d", i, o_wait, o_resp_cyc, m_ill ? 1 : 2); end
            total++; if ({o_taken, o_ill, o_mis, o_redir} !== {m_taken, m_ill, m_mis, m_redir}) begin
                bad++; $display("FAIL rnd_outcome[%0d] f=%b a=%h b=%h: got %b want %b", i, f, a, b, {o_taken, o_ill, o_mis, o_redir}, {m_taken, m_ill, m_mis, m_redir}); end
            total++; if (m_redir && (o_redir_pc !== m_target || o_redir_cyc !== stall + 1 || !o_hold_ok)) begin
                bad++; $display("FAIL rnd_redir[%0d]: got pc=%h cyc=%0d hold=%b want pc=%h cyc=%0d", i, o_redir_pc, o_redir_cyc, o_hold_ok, m_target, stall + 1); end
            total++; if (!o_cmp_ok || !o_busy_ok || o_ready_after !== 1'b1) begin
                bad++; $display("FAIL rnd_ctrl[%0d]: got cmp=%b busy=%b rdy=%b want 1 1 1", i, o_cmp_ok, o_busy_ok, o_ready_after); end
            total++; if ({bus.stat_branches, bus.stat_taken, bus2.stat_branches, bus2.stat_taken} !== {exp_br, exp_tk, exp2_br, exp2_tk}) begin
                bad++; $display("FAIL rnd_stats[%0d]: got %0d %0d %0d %0d want %0d %0d %0d %0d", i, bus.stat_branches, bus.stat_taken,
                                 bus2.stat_branches, bus2.stat_taken, exp_br, exp_tk, exp2_br, exp2_tk); end
        end
    endtask

    task automatic test_reset_in_redir();
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin tick(); guard++; end
        bus.req_funct3 = 3'b000; bus.req_rs1 = 32'd7; bus.req_rs2 = 32'd7;
        bus.req_pc = 32'h600; bus.req_imm = 32'h40; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        total++; if (bus.redir_valid !== 1'b1) begin bad++; $display("FAIL rst_redir_pre: got %b want 1", bus.redir_valid); end
        reset = 1'b1;
        tick();
        model_reset();
        total++; if (bus.redir_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.redir_pc !== 32'h0) begin
            bad++; $display("FAIL rst_redir_post: got v=%b rdy=%b pc=%h want 0 1 0", bus.redir_valid, bus.req_ready, bus.redir_pc); end
        total++; if ({bus.stat_branches, bus.stat_taken} !== {exp_br, exp_tk}) begin
            bad++; $display("FAIL rst_redir_stats: got %0d %0d want 0 0", bus.stat_branches, bus.stat_taken); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            model_apply(3'b000, 32'd1, 32'd2, 32'h700, 32'h4);
            drive_branch(3'b000, 32'd1, 32'd2, 32'h700, 32'h4, 0);
        end
        total++; if (bus2.stat_branches !== exp2_br || exp2_br !== 2'd3) begin
            bad++; $display("FAIL sat_cnt2: got %0d want %0d", bus2.stat_branches, exp2_br); end
        total++; if (bus.stat_branches !== exp_br) begin bad++; $display("FAIL sat_cnt32: got %0d want %0d", bus.stat_branches, exp_br); end
    endtask

    initial begin
        bus.redir_ready = 1'b0;
        bus.req_valid   = 1'b0;
        test_reset();
        test_beq_taken();
        test_signed_unsigned();
        test_illegal();
        test_redir_stall();
        test_wrap_misalign();
        test_back_to_back();
        test_random();
        test_reset_in_redir();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
